// File: rtl/skid_buffer_pkg.sv
// Shared types for the two-entry skid buffer: FSM state encoding and occupancy decode.
package skid_buffer_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  function automatic logic [1:0] occupancy(input state_t s);
    case (s)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/flopen.sv
// Enabled data register without reset; holds its value while en is low.
module flopen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: payload storage is deliberately not reset; the FSM state alone marks it valid or stale.
  always_ff @(posedge clk) begin
    if (en) q <= d;
  end

endmodule

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer; in_ready decodes from state only, never from out_ready.
// Optional flush input is compiled in when SKID_BUFFER_FLUSH_EN is defined.
module skid_buffer
  import skid_buffer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
`ifdef SKID_BUFFER_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  state_t           state, next_state;
  logic             push, pop;
  logic             main_en, skid_en;
  logic [WIDTH-1:0] main_d, skid_q;

  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign count     = occupancy(state);

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    main_en    = 1'b0;
    skid_en    = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          next_state = ONE;
          main_en    = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          main_en = 1'b1;
        end else if (push) begin
          next_state = FULL;
          skid_en    = 1'b1;
        end else if (pop) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          next_state = ONE;
          main_en    = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
`ifdef SKID_BUFFER_FLUSH_EN
    // Register writes in a flush cycle are harmless: EMPTY marks the contents stale.
    if (flush) next_state = EMPTY;
`endif
  end

  // Refilling main from skid keeps the older beat at the head of the queue.
  assign main_d = (state == FULL) ? skid_q : in_data;

  flopen #(.WIDTH(WIDTH)) u_main (
    .clk (clk),
    .en  (main_en),
    .d   (main_d),
    .q   (out_data)
  );

  flopen #(.WIDTH(WIDTH)) u_skid (
    .clk (clk),
    .en  (skid_en),
    .d   (in_data),
    .q   (skid_q)
  );

endmodule
